// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I decode types, opcodes and immediate helper
package riscv_pkg;

    typedef enum logic [3:0] {
        OP_NONE    = 4'd0,
        OP_LUI     = 4'd1,
        OP_AUIPC   = 4'd2,
        OP_JAL     = 4'd3,
        OP_JALR    = 4'd4,
        OP_BRANCH  = 4'd5,
        OP_LOAD    = 4'd6,
        OP_STORE   = 4'd7,
        OP_OPIMM   = 4'd8,
        OP_OP      = 4'd9,
        OP_FENCE   = 4'd10,
        OP_SYSTEM  = 4'd11,
        OP_ILLEGAL = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        op_e         op;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        rs1_en;
        logic        rs2_en;
        logic [31:0] imm;
        logic        illegal;
    } idu_bundle_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_I:   imm = {{21{ins[31]}}, ins[30:20]};
            IMM_S:   imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/u_idu_dec.sv
// rtl/u_idu_dec.sv - combinational RV32I instruction decoder
module u_idu_dec
    import riscv_pkg::*;
(
    input  logic [31:0]  ins,
    output idu_bundle_t  bundle
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_e       imm_sel;
    op_e        op;
    logic       wr, use1, use2, bad;

    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];

    always_comb begin
        op      = OP_ILLEGAL;
        imm_sel = IMM_NONE;
        wr      = 1'b0;
        use1    = 1'b0;
        use2    = 1'b0;
        bad     = 1'b0;
        // opcode includes ins[1:0], so compressed encodings fall into default
        case (opcode)
            OPC_LUI:    begin op = OP_LUI;    imm_sel = IMM_U; wr = 1'b1; end
            OPC_AUIPC:  begin op = OP_AUIPC;  imm_sel = IMM_U; wr = 1'b1; end
            OPC_JAL:    begin op = OP_JAL;    imm_sel = IMM_J; wr = 1'b1; end
            OPC_JALR: begin
                op = OP_JALR; imm_sel = IMM_I; wr = 1'b1; use1 = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                op = OP_BRANCH; imm_sel = IMM_B; use1 = 1'b1; use2 = 1'b1;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                op = OP_LOAD; imm_sel = IMM_I; wr = 1'b1; use1 = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                op = OP_STORE; imm_sel = IMM_S; use1 = 1'b1; use2 = 1'b1;
                bad = (funct3 >= 3'b011);
            end
            OPC_OPIMM: begin
                op = OP_OPIMM; imm_sel = IMM_I; wr = 1'b1; use1 = 1'b1;
                bad = ((funct3 == 3'b001) && (funct7 != F7_ZERO)) ||
                      ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT));
            end
            OPC_OP: begin
                op = OP_OP; wr = 1'b1; use1 = 1'b1; use2 = 1'b1;
                bad = ((funct7 != F7_ZERO) && (funct7 != F7_ALT)) ||
                      ((funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101));
            end
            OPC_FENCE:  begin op = OP_FENCE; end
            OPC_SYSTEM: begin op = OP_SYSTEM; imm_sel = IMM_I; wr = 1'b1; end
            default:    begin bad = 1'b1; end
        endcase
    end

    always_comb begin
        bundle         = '0;
        bundle.op      = op;
        bundle.funct3  = funct3;
        bundle.alt     = ins[30];
        bundle.rd      = ins[11:7];
        bundle.rs1     = ins[19:15];
        bundle.rs2     = ins[24:20];
        bundle.rd_we   = wr && !bad && (ins[11:7] != 5'd0);
        bundle.rs1_en  = use1 && !bad;
        bundle.rs2_en  = use2 && !bad;
        bundle.imm     = imm_gen(ins, imm_sel);
        bundle.illegal = bad;
    end

endmodule

// File: rtl/u_idu.sv
// rtl/u_idu.sv - decode stage: slot qualification FSM and registered bundle
module u_idu
    import riscv_pkg::*;
#(
    parameter int WARMUP = 2,
    parameter int KILL_N = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] ifu_pc,
    input  logic [31:0] ifu_ins,
    input  logic        ex_flush,
    output logic        idu_valid,
    output logic [31:0] idu_pc,
    output logic [31:0] idu_ins,
    output logic [3:0]  idu_op,
    output logic [2:0]  idu_funct3,
    output logic        idu_alt,
    output logic [4:0]  idu_rd,
    output logic [4:0]  idu_rs1,
    output logic [4:0]  idu_rs2,
    output logic        idu_rd_we,
    output logic        idu_rs1_en,
    output logic        idu_rs2_en,
    output logic [31:0] idu_imm,
    output logic        idu_illegal
);

    localparam int MAXC = (WARMUP > KILL_N) ? WARMUP : KILL_N;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) + 1 : 1;
    localparam logic [CW-1:0] WARM_INIT = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CW-1:0] KILL_INIT = CW'((KILL_N > 1) ? KILL_N - 2 : 0);

    typedef enum logic [1:0] {
        S_WARM,
        S_RUN,
        S_KILL
    } state_e;

    localparam state_e RESET_STATE = (WARMUP == 0) ? S_RUN : S_WARM;

    state_e        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    idu_bundle_t   dec;

    u_idu_dec u_dec (
        .ins    (ifu_ins),
        .bundle (dec)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RESET_STATE;
            cnt   <= WARM_INIT;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            S_WARM: begin
                if (cnt == '0) state_nxt = S_RUN;
                else           cnt_nxt   = cnt - CW'(1);
            end
            S_RUN: begin
                if (!ex_flush) begin
                    accept = 1'b1;
                end else if (KILL_N > 1) begin
                    state_nxt = S_KILL;
                    cnt_nxt   = KILL_INIT;
                end
            end
            S_KILL: begin
                if (ex_flush)        cnt_nxt   = KILL_INIT;
                else if (cnt == '0)  state_nxt = S_RUN;
                else                 cnt_nxt   = cnt - CW'(1);
            end
            default: begin
                state_nxt = RESET_STATE;
                cnt_nxt   = WARM_INIT;
            end
        endcase
    end

    // payload registers only load on accepted slots so dead slots cause no toggling
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idu_valid   <= 1'b0;
            idu_pc      <= '0;
            idu_ins     <= '0;
            idu_op      <= OP_NONE;
            idu_funct3  <= '0;
            idu_alt     <= 1'b0;
            idu_rd      <= '0;
            idu_rs1     <= '0;
            idu_rs2     <= '0;
            idu_rd_we   <= 1'b0;
            idu_rs1_en  <= 1'b0;
            idu_rs2_en  <= 1'b0;
            idu_imm     <= '0;
            idu_illegal <= 1'b0;
        end else begin
            idu_valid <= accept;
            if (accept) begin
                idu_pc      <= ifu_pc;
                idu_ins     <= ifu_ins;
                idu_op      <= dec.op;
                idu_funct3  <= dec.funct3;
                idu_alt     <= dec.alt;
                idu_rd      <= dec.rd;
                idu_rs1     <= dec.rs1;
                idu_rs2     <= dec.rs2;
                idu_rd_we   <= dec.rd_we;
                idu_rs1_en  <= dec.rs1_en;
                idu_rs2_en  <= dec.rs2_en;
                idu_imm     <= dec.imm;
                idu_illegal <= dec.illegal;
            end
        end
    end

endmodule

// File: tb/tb_u_idu.sv
// tb/tb_u_idu.sv - randomized self-checking bench for u_idu against a behavioural model
module tb_u_idu;

    localparam int WARMUP = 2;
    localparam int KILL_N = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] ifu_pc = '0;
    logic [31:0] ifu_ins = '0;
    logic        ex_flush = 1'b0;
    logic        idu_valid;
    logic [31:0] idu_pc, idu_ins, idu_imm;
    logic [3:0]  idu_op;
    logic [2:0]  idu_funct3;
    logic        idu_alt, idu_rd_we, idu_rs1_en, idu_rs2_en, idu_illegal;
    logic [4:0]  idu_rd, idu_rs1, idu_rs2;

    always #5 clk = ~clk;

    u_idu #(.WARMUP(WARMUP), .KILL_N(KILL_N)) dut (
        .clk(clk), .rstn(rstn), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins), .ex_flush(ex_flush),
        .idu_valid(idu_valid), .idu_pc(idu_pc), .idu_ins(idu_ins), .idu_op(idu_op),
        .idu_funct3(idu_funct3), .idu_alt(idu_alt), .idu_rd(idu_rd), .idu_rs1(idu_rs1),
        .idu_rs2(idu_rs2), .idu_rd_we(idu_rd_we), .idu_rs1_en(idu_rs1_en),
        .idu_rs2_en(idu_rs2_en), .idu_imm(idu_imm), .idu_illegal(idu_illegal)
    );

    typedef struct {
        int          op;
        logic [31:0] imm;
        logic        we, r1, r2, bad;
    } dec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // immediates built as signed integers from the ISA field layout
    function automatic dec_t model_dec(input logic [31:0] w);
        dec_t d;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        int iv = int'(w[31:20]) - (w[31] ? 4096 : 0);
        int sv = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
        int bv = 2 * int'({w[31], w[7], w[30:25], w[11:8]}) - (w[31] ? 8192 : 0);
        int jv = 2 * int'({w[31], w[19:12], w[20], w[30:21]}) - (w[31] ? (1 << 21) : 0);
        int uv = int'(w[31:12]) * 4096;
        d = '{op: 12, imm: 32'd0, we: 1'b0, r1: 1'b0, r2: 1'b0, bad: 1'b0};
        case (w[6:0])
            7'h37: begin d.op = 1;  d.imm = uv; d.we = 1; end
            7'h17: begin d.op = 2;  d.imm = uv; d.we = 1; end
            7'h6F: begin d.op = 3;  d.imm = jv; d.we = 1; end
            7'h67: begin d.op = 4;  d.imm = iv; d.we = 1; d.r1 = 1; d.bad = (f3 != 0); end
            7'h63: begin d.op = 5;  d.imm = bv; d.r1 = 1; d.r2 = 1; d.bad = (f3 == 2 || f3 == 3); end
            7'h03: begin d.op = 6;  d.imm = iv; d.we = 1; d.r1 = 1; d.bad = (f3 == 3 || f3 >= 6); end
            7'h23: begin d.op = 7;  d.imm = sv; d.r1 = 1; d.r2 = 1; d.bad = (f3 >= 3); end
            7'h13: begin
                d.op = 8; d.imm = iv; d.we = 1; d.r1 = 1;
                d.bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            end
            7'h33: begin
                d.op = 9; d.we = 1; d.r1 = 1; d.r2 = 1;
                d.bad = (f7 != 0 && f7 != 32) || (f7 == 32 && f3 != 0 && f3 != 5);
            end
            7'h0F: begin d.op = 10; end
            7'h73: begin d.op = 11; d.imm = iv; d.we = 1; end
            default: d.bad = 1;
        endcase
        if (d.bad) begin
            d.we = 0; d.r1 = 0; d.r2 = 0;
        end
        if (w[11:7] == 5'd0) d.we = 0;
        return d;
    endfunction

    // expected outputs: hold on discarded slots, load on accepted ones
    logic        e_valid;
    logic [31:0] e_pc, e_ins;
    dec_t        e_dec;
    int          m_idx, m_kill;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_valid = 0; e_pc = 0; e_ins = 0;
            e_dec = '{op: 0, imm: 32'd0, we: 1'b0, r1: 1'b0, r2: 1'b0, bad: 1'b0};
            m_idx = 0; m_kill = 0;
        end else if (m_idx < WARMUP) begin
            m_idx++;
            e_valid = 0;
        end else if (ex_flush) begin
            e_valid = 0;
            m_kill = KILL_N - 1;
        end else if (m_kill > 0) begin
            e_valid = 0;
            m_kill--;
        end else begin
            e_valid = 1;
            e_pc = ifu_pc;
            e_ins = ifu_ins;
            e_dec = model_dec(ifu_ins);
        end
    end

    always @(negedge clk) begin
        cmp("valid",   {31'd0, idu_valid},   {31'd0, e_valid});
        cmp("pc",      idu_pc,               e_pc);
        cmp("ins",     idu_ins,              e_ins);
        cmp("op",      {28'd0, idu_op},      e_dec.op);
        cmp("funct3",  {29'd0, idu_funct3},  {29'd0, e_ins[14:12]});
        cmp("alt",     {31'd0, idu_alt},     {31'd0, e_ins[30]});
        cmp("rd",      {27'd0, idu_rd},      {27'd0, e_ins[11:7]});
        cmp("rs1",     {27'd0, idu_rs1},     {27'd0, e_ins[19:15]});
        cmp("rs2",     {27'd0, idu_rs2},     {27'd0, e_ins[24:20]});
        cmp("rd_we",   {31'd0, idu_rd_we},   {31'd0, e_dec.we});
        cmp("rs1_en",  {31'd0, idu_rs1_en},  {31'd0, e_dec.r1});
        cmp("rs2_en",  {31'd0, idu_rs2_en},  {31'd0, e_dec.r2});
        cmp("imm",     idu_imm,              e_dec.imm);
        cmp("illegal", {31'd0, idu_illegal}, {31'd0, e_dec.bad});
    end

    // inputs change 2 time units after an edge; the task returns just after the sampling edge
    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic fl);
        ifu_pc = pc;
        ifu_ins = ins;
        ex_flush = fl;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 3) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    logic [31:0] pc;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        cmp("lit_rst_valid", {31'd0, idu_valid}, 32'd0);
        cmp("lit_rst_op", {28'd0, idu_op}, 32'd0);
        cmp("lit_rst_imm", idu_imm, 32'd0);
        rstn = 1'b1;

        drive(32'd0, 32'h00500093, 1'b0);
        cmp("lit_warm1_valid", {31'd0, idu_valid}, 32'd0);
        drive(32'd4, 32'h00500093, 1'b0);
        cmp("lit_warm2_valid", {31'd0, idu_valid}, 32'd0);
        drive(32'd8, 32'h00500093, 1'b0);
        cmp("lit_first_valid", {31'd0, idu_valid}, 32'd1);
        cmp("lit_first_pc", idu_pc, 32'd8);
        cmp("lit_addi_op", {28'd0, idu_op}, 32'd8);
        cmp("lit_addi_rd", {27'd0, idu_rd}, 32'd1);
        cmp("lit_addi_en", {29'd0, idu_rd_we, idu_rs1_en, idu_rs2_en}, 32'b110);
        cmp("lit_addi_imm", idu_imm, 32'h5);

        drive(32'd12, 32'hFE20AE23, 1'b0);
        cmp("lit_sw_op", {28'd0, idu_op}, 32'd7);
        cmp("lit_sw_regs", {22'd0, idu_rs1, idu_rs2}, {22'd0, 5'd1, 5'd2});
        cmp("lit_sw_we", {31'd0, idu_rd_we}, 32'd0);
        cmp("lit_sw_imm", idu_imm, 32'hFFFFFFFC);
        drive(32'd16, 32'h008000EF, 1'b0);
        cmp("lit_jal_op", {28'd0, idu_op}, 32'd3);
        cmp("lit_jal_imm", idu_imm, 32'h8);
        drive(32'd20, 32'h123452B7, 1'b0);
        cmp("lit_lui_imm", idu_imm, 32'h12345000);
        cmp("lit_lui_rd", {27'd0, idu_rd}, 32'd5);
        drive(32'd24, 32'h00000000, 1'b0);
        cmp("lit_zero_ill", {30'd0, idu_illegal, idu_valid}, 32'b11);
        cmp("lit_zero_we", {31'd0, idu_rd_we}, 32'd0);
        drive(32'd28, 32'h40001013, 1'b0);
        cmp("lit_slli_ill", {30'd0, idu_illegal, idu_valid}, 32'b11);

        drive(32'd32, 32'h00500093, 1'b1);
        cmp("lit_fl1_valid", {31'd0, idu_valid}, 32'd0);
        cmp("lit_fl1_hold", idu_pc, 32'd28);
        drive(32'd36, 32'h00500093, 1'b0);
        cmp("lit_fl2_valid", {31'd0, idu_valid}, 32'd0);
        drive(32'd40, 32'h00500093, 1'b0);
        cmp("lit_fl3_valid", {31'd0, idu_valid}, 32'd1);
        drive(32'd44, 32'h00500093, 1'b1);
        drive(32'd48, 32'h00500093, 1'b0);
        drive(32'd52, 32'h00500093, 1'b1);
        cmp("lit_ext1_valid", {31'd0, idu_valid}, 32'd0);
        drive(32'd56, 32'h00500093, 1'b0);
        cmp("lit_ext2_valid", {31'd0, idu_valid}, 32'd0);
        cmp("lit_ext2_hold", idu_pc, 32'd40);
        drive(32'd60, 32'h00500093, 1'b0);
        cmp("lit_ext3_valid", {31'd0, idu_valid}, 32'd1);

        pc = 32'd64;
        for (int i = 0; i < 400; i++) begin
            drive(pc, rand_ins(), ($urandom_range(0, 7) == 0));
            pc += 4;
        end

        rstn = 1'b0;
        #1;
        cmp("lit_async_valid", {31'd0, idu_valid}, 32'd0);
        cmp("lit_async_pc", idu_pc, 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(pc, rand_ins(), ($urandom_range(0, 5) == 0));
            pc += 4;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/u_idu.md
# u_idu

Instruction decode stage of the RV32I core. It consumes the free-running fetch stream (`ifu_pc`/`ifu_ins`) from the fetch unit and produces a registered, fully decoded instruction bundle for the execute stage. It generates the valid qualifier that fetch lacks:
- masks the post-reset warm-up cycles;
- kills the branch-shadow slots on an execute-stage flush;
- flags illegal encodings.

## Interface
- `WARMUP`, default 2: cycles after reset release during which fetch outputs are discarded.
- `KILL_N`, default 2: number of consecutive input slots discarded per flush.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `ifu_pc`  in  32  PC of `ifu_ins`.
- `ifu_ins`  in  32  fetched instruction word.
- `ex_flush`  in  1  execute-stage redirect; kills the slot presented this cycle and later slots.
- `idu_valid`  out  1  bundle valid.
- `idu_pc`  out  32  registered PC.
- `idu_ins`  out  32  registered raw instruction.
- `idu_op`  out  4  `op_e` class.
- `idu_funct3`  out  3  `ins[14:12]`.
- `idu_alt`  out  1  `ins[30]` (SUB/SRA select).
- `idu_rd`, `idu_rs1`, `idu_rs2`  out  5 each  register indices.
- `idu_rd_we`  out  1  rd write enable; 0 when rd is x0.
- `idu_rs1_en`, `idu_rs2_en`  out  1 each  source used.
- `idu_imm`  out  32  sign-extended immediate.
- `idu_illegal`  out  1  illegal encoding; valid slot only.

## Operation
- FSM states are S_WARM, S_RUN and S_KILL. A down-counter `cnt` of width $clog2(max(WARMUP,KILL_N))+1 backs the WARM and KILL states.
- Reset enters S_WARM with `cnt`=WARMUP-1. If WARMUP=0, reset enters S_RUN directly.
- S_WARM: the slot is discarded. When `cnt`==0, go to S_RUN; otherwise decrement.
- S_RUN: the slot is accepted, unless `ex_flush`=1. A flush discards the slot and goes to S_KILL with `cnt`=KILL_N-2. If KILL_N=1, it stays in S_RUN.
- S_KILL: the slot is discarded.
  - `ex_flush`=1 reloads `cnt`=KILL_N-2 and the state stays S_KILL.
  - Otherwise, `cnt`==0 goes to S_RUN; else decrement.
- Flush in S_WARM is ignored; warm-up completes normally.
- Discarded slot:
  - `idu_valid`=0.
  - All other outputs hold their previous value. No toggling on dead slots.
- Accepted slot: all outputs load from the decode of `ifu_ins`, and `idu_valid`=1.
- Decode, by opcode `ins[6:0]`:
  - 0110111 → OP_LUI, U-imm.
  - 0010111 → OP_AUIPC, U-imm.
  - 1101111 → OP_JAL, J-imm.
  - 1100111 → OP_JALR, I-imm.
  - 1100011 → OP_BRANCH, B-imm.
  - 0000011 → OP_LOAD, I-imm.
  - 0100011 → OP_STORE, S-imm.
  - 0010011 → OP_OPIMM, I-imm.
  - 0110011 → OP_OP, imm 0.
  - 0001111 → OP_FENCE.
  - 1110011 → OP_SYSTEM, I-imm.
  - Anything else → OP_ILLEGAL.
- Immediates: U = `{ins[31:12],12'b0}`. I, S, B and J are sign-extended from `ins[31]`. B and J have bit 0 = 0.
- Register usage:
  - rs1_en: JALR, BRANCH, LOAD, STORE, OPIMM, OP.
  - rs2_en: BRANCH, STORE, OP.
  - rd_we: LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, SYSTEM; and only when rd≠0.
- Illegal, `idu_illegal`=1 with rd_we, rs1_en and rs2_en forced to 0, when any of these holds:
  - `ins[1:0]`≠11;
  - opcode is unknown;
  - JALR with funct3≠000;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 011, 110 or 111;
  - STORE with funct3 ≥ 011;
  - OP with funct7 ∉ {0000000, 0100000};
  - OP with funct7=0100000 and funct3 ∉ {000, 101};
  - OPIMM funct3 001 with funct7≠0;
  - OPIMM funct3 101 with funct7 ∉ {0000000, 0100000}.
- As a consequence, 0x00000000 decodes as illegal.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `ex_flush` is sampled at the same edge as the slot it kills.
- There is no backpressure; one slot is consumed per cycle.
- Reset values: all outputs are 0, and `idu_op`=OP_NONE (0).
- Reset asserted mid-stream clears the outputs immediately (asynchronous) and restarts S_WARM.
- With defaults, the first accepted slot is the third rising edge after `rstn` rises. `idu_valid` rises after that edge.

## Structure
- Package `riscv_pkg` holds:
  - `op_e` (4-bit: OP_NONE=0, OP_LUI … OP_SYSTEM, OP_ILLEGAL);
  - `imm_e` (I/S/B/U/J/NONE);
  - opcode localparams;
  - the `idu_bundle_t` struct.
- Sub-module `u_idu_dec` is purely combinational: ins → bundle, including illegal. `u_idu` holds the FSM and output registers.

## Test plan
- Reset, then drive PC 0,4,8… with `ifu_ins` constant 0x00500093 → `idu_valid`=0 for the edges before the third edge after reset release; first valid `idu_pc`=8.
- 0x00500093 (`addi x1,x0,5`) → OP_OPIMM, rd=1, rd_we=1, rs1_en=1, rs2_en=0, imm=0x00000005.
- 0xFE20AE23 (`sw x2,-4(x1)`) → OP_STORE, rs1=1, rs2=2, rd_we=0, imm=0xFFFFFFFC.
- 0x008000EF (`jal x1,+8`) → OP_JAL, imm=0x00000008. 0x123452B7 (`lui`) → imm=0x12345000, rd=5.
- 0x00000000 and 0x40001013 → `idu_illegal`=1, `idu_valid`=1, rd_we=0.
- `ex_flush` pulse in S_RUN → `idu_valid` low for exactly 2 slots, outputs held. A second flush during S_KILL extends it to 2 slots after the second pulse.
